// File: rtl/mac_result_fifo_if.sv
// rtl/mac_result_fifo_if.sv - MAC result write strobe and consumer valid/ready handshake
interface mac_result_fifo_if #(
  parameter int DATA_W = 11
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Producer/consumer side (MAC plus downstream consumer)
  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  // FIFO side
  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/mac_result_fifo.sv
// rtl/mac_result_fifo.sv - circular result FIFO behind the MAC; optional saturation via MACRES_CLIP_EN
module mac_result_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  mac_result_fifo_if.slave  bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              clip_seen
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              pop;
  logic              push;
  logic              drop;
  logic [ADDR_W:0]   occ_after_pop;
  logic [DATA_W-1:0] wdata;

`ifdef MACRES_CLIP_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = {{(DATA_W-7){1'b0}}, 7'h7f};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {{(DATA_W-7){1'b1}}, 7'h00};

  logic clip_q, clip_d;
  logic clip_hit;

  // Saturate the incoming result to signed 8 bits, sign-extended to the storage width
  always_comb begin
    wdata    = bus.in_data;
    clip_hit = 1'b0;
    if ($signed(bus.in_data) > SAT_MAX) begin
      wdata    = SAT_MAX;
      clip_hit = 1'b1;
    end else if ($signed(bus.in_data) < SAT_MIN) begin
      wdata    = SAT_MIN;
      clip_hit = 1'b1;
    end
  end

  // Sticky clip flag, cleared by flush
  always_comb begin
    clip_d = clip_q | (push & clip_hit);
    if (flush) begin
      clip_d = 1'b0;
    end
  end

  // Clip flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_q <= 1'b0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip_seen = clip_q;
`else
  assign wdata     = bus.in_data;
  assign clip_seen = 1'b0;
`endif

  // Next-state for pointers, occupancy, flags and the registered head entry
  always_comb begin
    pop           = out_valid_q & bus.out_ready;
    push          = bus.in_valid & (~full_q | pop);
    drop          = bus.in_valid & full_q & ~pop;
    occ_after_pop = count_q - (ADDR_W+1)'(pop);

    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    count_d    = occ_after_pop + (ADDR_W+1)'(push);
    overflow_d = overflow_q | drop;

    // The head is the new write only when nothing else remains after the pop;
    // otherwise it is read from storage at the advanced read pointer.
    if (push && (occ_after_pop == '0)) begin
      out_data_d = wdata;
    end else if (occ_after_pop != '0) begin
      out_data_d = mem[rd_ptr_d];
    end else begin
      out_data_d = out_data_q;
    end

    full_d      = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d     = (count_d == '0);
    out_valid_d = (count_d != '0);

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      out_data_d  = '0;
      full_d      = 1'b0;
      empty_d     = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  // Control and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// tb/tb_mac_result_fifo.sv - table-driven and sequence checks for mac_result_fifo
module tb_mac_result_fifo;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clip_seen;

  int checks;
  int errors;

  mac_result_fifo_if #(.DATA_W(11)) bus ();

  mac_result_fifo #(.DATA_W(11), .DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .clip_seen (clip_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [10:0] data;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [10:0] e_data;
    logic [2:0]  e_count;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [29];

  // Value the FIFO is expected to store for a given input
  function automatic logic [10:0] stored(input logic [10:0] v);
`ifdef MACRES_CLIP_EN
    if ($signed(v) > 11'sd127) return 11'd127;
    if ($signed(v) < -11'sd128) return 11'h780;
    return v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [10:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
  endtask

  // Apply inputs, take one rising edge, sample 1 ns later
  task automatic step(input logic v, input logic [10:0] d, input logic r, input logic f);
    drive(v, d, r, f);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input int d, input logic r, input logic f,
                              input logic ev, input int ed, input int ec,
                              input logic ef, input logic ee, input logic eo);
    vec_t t;
    t.vld = v; t.data = 11'(d); t.rdy = r; t.fl = f;
    t.e_valid = ev; t.e_data = 11'(ed); t.e_count = 3'(ec);
    t.e_full = ef; t.e_empty = ee; t.e_ovf = eo;
    return t;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // Single push with immediate consumer
    vecs[0]  = mk(1, 392,   1, 0, 1, 392,   1, 0, 0, 0);
    vecs[1]  = mk(0, 0,     1, 0, 0, 0,     0, 0, 1, 0);
    // Fill with back-pressure, hold, then drain in order
    vecs[2]  = mk(1, -5,    0, 0, 1, -5,    1, 0, 0, 0);
    vecs[3]  = mk(1, 17,    0, 0, 1, -5,    2, 0, 0, 0);
    vecs[4]  = mk(1, -1024, 0, 0, 1, -5,    3, 0, 0, 0);
    vecs[5]  = mk(1, 1023,  0, 0, 1, -5,    4, 1, 0, 0);
    vecs[6]  = mk(0, 0,     0, 0, 1, -5,    4, 1, 0, 0);
    vecs[7]  = mk(0, 0,     1, 0, 1, 17,    3, 0, 0, 0);
    vecs[8]  = mk(0, 0,     1, 0, 1, -1024, 2, 0, 0, 0);
    vecs[9]  = mk(0, 0,     1, 0, 1, 1023,  1, 0, 0, 0);
    vecs[10] = mk(0, 0,     1, 0, 0, 0,     0, 0, 1, 0);
    // Full with simultaneous push and pop: slot reused, no drop
    vecs[11] = mk(1, 1,     0, 0, 1, 1,     1, 0, 0, 0);
    vecs[12] = mk(1, 2,     0, 0, 1, 1,     2, 0, 0, 0);
    vecs[13] = mk(1, 3,     0, 0, 1, 1,     3, 0, 0, 0);
    vecs[14] = mk(1, 4,     0, 0, 1, 1,     4, 1, 0, 0);
    vecs[15] = mk(1, 5,     1, 0, 1, 2,     4, 1, 0, 0);
    vecs[16] = mk(0, 0,     1, 0, 1, 3,     3, 0, 0, 0);
    vecs[17] = mk(0, 0,     1, 0, 1, 4,     2, 0, 0, 0);
    vecs[18] = mk(0, 0,     1, 0, 1, 5,     1, 0, 0, 0);
    vecs[19] = mk(0, 0,     1, 0, 0, 0,     0, 0, 1, 0);
    // Full without pop drops; overflow sticks until flush
    vecs[20] = mk(1, 6,     0, 0, 1, 6,     1, 0, 0, 0);
    vecs[21] = mk(1, 7,     0, 0, 1, 6,     2, 0, 0, 0);
    vecs[22] = mk(1, 8,     0, 0, 1, 6,     3, 0, 0, 0);
    vecs[23] = mk(1, 9,     0, 0, 1, 6,     4, 1, 0, 0);
    vecs[24] = mk(1, 100,   0, 0, 1, 6,     4, 1, 0, 1);
    vecs[25] = mk(0, 0,     0, 0, 1, 6,     4, 1, 0, 1);
    vecs[26] = mk(1, 55,    1, 1, 0, 0,     0, 0, 1, 0);
    vecs[27] = mk(1, 42,    0, 0, 1, 42,    1, 0, 0, 0);
    vecs[28] = mk(0, 0,     1, 0, 0, 0,     0, 0, 1, 0);

    drive(0, 11'd0, 0, 0);
    reset = 1'b0;
    #22;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_clip_seen", 32'(clip_seen), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      step(vecs[i].vld, vecs[i].data, vecs[i].rdy, vecs[i].fl);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid || vecs[i].fl)
        chk($sformatf("vec%0d_data", i), 32'(bus.out_data),
            32'(vecs[i].fl ? 11'd0 : stored(vecs[i].e_data)));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Interleaved push/pop pairs wrap both pointers twice
    for (int v = 1; v <= 10; v++) begin
      step(1, 11'(v), 0, 0);
      chk($sformatf("wrap%0d_valid", v), 32'(bus.out_valid), 32'd1);
      chk($sformatf("wrap%0d_data", v), 32'(bus.out_data), 32'(v));
      step(0, 11'd0, 1, 0);
      chk($sformatf("wrap%0d_drained", v), 32'(empty), 32'd1);
    end

    // Asynchronous reset mid-drain with three entries held
    step(1, 11'd10, 0, 0);
    step(1, 11'd11, 0, 0);
    step(1, 11'd12, 0, 0);
    chk("pre_reset_count", 32'(count), 32'd3);
    drive(0, 11'd0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step(0, 11'd0, 1, 0);
    chk("post_reset_no_pulse", 32'(bus.out_valid), 32'd0);
    step(1, 11'd77, 0, 0);
    chk("post_reset_valid", 32'(bus.out_valid), 32'd1);
    chk("post_reset_data", 32'(bus.out_data), 32'd77);
    step(0, 11'd0, 1, 0);
    chk("post_reset_empty", 32'(empty), 32'd1);

`ifdef MACRES_CLIP_EN
    step(1, 11'd392, 1, 0);
    chk("clip_hi_data", 32'(bus.out_data), 32'd127);
    chk("clip_hi_seen", 32'(clip_seen), 32'd1);
    step(1, 11'(-300), 1, 0);
    chk("clip_lo_data", 32'(bus.out_data), 32'h780);
    step(1, 11'd50, 1, 0);
    chk("clip_pass_data", 32'(bus.out_data), 32'd50);
    chk("clip_still_seen", 32'(clip_seen), 32'd1);
    step(0, 11'd0, 0, 1);
    chk("clip_flush", 32'(clip_seen), 32'd0);
`else
    chk("clip_tied_low", 32'(clip_seen), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
